// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the Harvard MIPS memory responder.
// Holds the run-monitor states and the byte-address to word-index decoder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_t;

    localparam logic [31:0] INSTR_BASE_DEF = 32'hBFC00000;
    localparam logic [31:0] DATA_BASE_DEF  = 32'h00000000;
    localparam logic [31:0] NOP            = 32'h00000000;

    typedef struct packed {
        logic        hit;
        logic [29:0] idx;
    } word_dec_t;

    // Addresses below the base wrap to large offsets and fall outside the window.
    function automatic word_dec_t word_index(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] words);
        logic [31:0] off;
        word_dec_t   res;
        off     = addr - base;
        res.idx = off[31:2];
        res.hit = (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < words);
        return res;
    endfunction

endpackage

// File: rtl/mips_mem_window.sv
// Word array behind a byte-addressed window: combinational read, posedge write.
// The preload port takes priority over the CPU write port on the same edge.
module mips_mem_window
    import mips_mem_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter logic [31:0] BASE  = 32'h00000000
) (
    input  logic        clk_i,
    input  logic [31:0] addr_i,
    output logic        hit_o,
    output logic [31:0] rdata_o,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic        load_en_i,
    input  logic [31:0] load_word_i,
    input  logic [31:0] load_data_i
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem_q [WORDS];
    word_dec_t     dec;
    logic [AW-1:0] idx;
    logic          load_ok;

    assign dec     = word_index(addr_i, BASE, WORDS);
    assign idx     = dec.idx[AW-1:0];
    assign hit_o   = dec.hit && ((dec.idx >> AW) == '0);
    assign rdata_o = mem_q[idx];
    assign load_ok = load_en_i && (load_word_i < WORDS);

    always_ff @(posedge clk_i) begin
        if (load_ok) begin
            mem_q[load_word_i[AW-1:0]] <= load_data_i;
        end else if (cpu_we_i && hit_o) begin
            mem_q[idx] <= cpu_wdata_i;
        end
    end

endmodule

// File: rtl/mips_harvard_mem.sv
// Instruction ROM + data RAM responder for mips_cpu_harvard, with a run monitor
// reporting completion, timeout and the first bus fault.
module mips_harvard_mem
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] INSTR_BASE     = INSTR_BASE_DEF,
    parameter int unsigned INSTR_WORDS    = 1024,
    parameter logic [31:0] DATA_BASE      = DATA_BASE_DEF,
    parameter int unsigned DATA_WORDS     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        active,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    input  logic        load_en,
    input  logic        load_sel,
    input  logic [31:0] load_word,
    input  logic [31:0] load_data,
    output logic        done,
    output logic        timeout,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] cycle_count
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic        rom_hit, ram_hit;
    logic [31:0] rom_rdata, ram_rdata;
    run_state_t  state_q, state_d;
    logic [31:0] count_q, count_d, count_inc;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        mon_en, data_fault, instr_fault, fault_now, ram_we;

    mips_mem_window #(.WORDS(INSTR_WORDS), .BASE(INSTR_BASE)) u_rom (
        .clk_i       (clk),
        .addr_i      (instr_address),
        .hit_o       (rom_hit),
        .rdata_o     (rom_rdata),
        .cpu_we_i    (1'b0),
        .cpu_wdata_i (32'h0),
        .load_en_i   (load_en && !load_sel),
        .load_word_i (load_word),
        .load_data_i (load_data)
    );

    mips_mem_window #(.WORDS(DATA_WORDS), .BASE(DATA_BASE)) u_ram (
        .clk_i       (clk),
        .addr_i      (data_address),
        .hit_o       (ram_hit),
        .rdata_o     (ram_rdata),
        .cpu_we_i    (ram_we),
        .cpu_wdata_i (data_writedata),
        .load_en_i   (load_en && load_sel),
        .load_word_i (load_word),
        .load_data_i (load_data)
    );

    assign instr_readdata = rom_hit ? rom_rdata : NOP;
    assign data_readdata  = (data_read && ram_hit) ? ram_rdata : 32'h0;

    // Bus errors are only policed while the program is running.
    assign mon_en      = clk_enable && (state_q == ST_RUN);
    assign data_fault  = (data_read && data_write) || ((data_read || data_write) && !ram_hit);
    assign instr_fault = active && !rom_hit;
    assign fault_now   = mon_en && (data_fault || instr_fault);
    assign ram_we      = clk_enable && data_write && !fault_now;
    assign count_inc   = (count_q == '1) ? count_q : count_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Completion is checked before the budget so a simultaneous finish counts as DONE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clk_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (active) state_d = ST_RUN;
                end
                ST_RUN: begin
                    count_d = count_inc;
                    if (!active)                         state_d = ST_DONE;
                    else if (count_inc >= TIMEOUT_LAST)  state_d = ST_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (fault_now && !fault_q) begin
            fault_d      = 1'b1;
            fault_addr_d = data_fault ? data_address : instr_address;
        end
    end

    always_comb begin
        done        = (state_q == ST_DONE);
        timeout     = (state_q == ST_TIMEOUT);
        fault       = fault_q;
        fault_addr  = fault_addr_q;
        cycle_count = count_q;
    end

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Self-checking bench for mips_harvard_mem: random reads/writes against array
// models, plus directed run-monitor, fault, timeout and reset scenarios.
module tb_mips_harvard_mem;

    localparam logic [31:0] IB = 32'hBFC00000;
    localparam int W = 1024;
    localparam int T = 10000;

    logic        clk = 1'b0;
    logic        reset, clk_enable, active;
    logic [31:0] instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_write, data_read;
    logic        load_en, load_sel;
    logic [31:0] load_word, load_data;
    logic        done, timeout, fault;
    logic [31:0] fault_addr, cycle_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom_m [W];
    logic [31:0] ram_m [W];

    mips_harvard_mem dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata),
        .load_en(load_en), .load_sel(load_sel), .load_word(load_word), .load_data(load_data),
        .done(done), .timeout(timeout), .fault(fault), .fault_addr(fault_addr),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_instr(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - IB;
        if (off < 4 * W && off % 4 == 0) return rom_m[off / 4];
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] addr, input logic rd);
        if (rd && addr < 4 * W && addr % 4 == 0) return ram_m[addr / 4];
        return 32'h0;
    endfunction

    task automatic load(input logic sel, input logic [31:0] word, input logic [31:0] dat);
        load_en = 1'b1; load_sel = sel; load_word = word; load_data = dat;
        cyc();
        load_en = 1'b0;
        if (word < W) begin
            if (sel) ram_m[word] = dat;
            else     rom_m[word] = dat;
        end
    endtask

    task automatic start_run();
        active = 1'b0; data_read = 1'b0; data_write = 1'b0; instr_address = IB;
        reset = 1'b1;
        cyc();
        reset = 1'b0; clk_enable = 1'b1; active = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; clk_enable = 1'b0; active = 1'b0;
        cyc(); cyc();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
        checks++; if (fault_addr !== 32'h0) begin errors++; $display("FAIL reset_fault_addr got %h exp 0", fault_addr); end
        checks++; if (cycle_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", cycle_count); end
        for (int i = 0; i < W; i++) begin
            load(1'b0, i, $urandom);
            load(1'b1, i, $urandom);
        end
        load(1'b0, 0, 32'h24010014);
        load(1'b1, W, 32'hDEADBEEF);
        load(1'b1, 32'h80000000, 32'hCAFEF00D);
        load(1'b0, W + 3, 32'h12345678);
        reset = 1'b0; clk_enable = 1'b1;
        cyc();
    endtask

    task automatic test_instr_read();
        logic [31:0] a;
        instr_address = IB; #1;
        checks++; if (instr_readdata !== 32'h24010014) begin errors++; $display("FAIL fetch_vector got %h exp 24010014", instr_readdata); end
        instr_address = IB - 4; #1;
        checks++; if (instr_readdata !== 32'h0) begin errors++; $display("FAIL fetch_below got %h exp 0", instr_readdata); end
        instr_address = IB + 4 * (W - 1); #1;
        checks++; if (instr_readdata !== rom_m[W-1]) begin errors++; $display("FAIL fetch_last got %h exp %h", instr_readdata, rom_m[W-1]); end
        instr_address = IB + 4 * W; #1;
        checks++; if (instr_readdata !== 32'h0) begin errors++; $display("FAIL fetch_above got %h exp 0", instr_readdata); end
        for (int i = 0; i < 60; i++) begin
            case ($urandom % 4)
                0, 1:    a = IB + 4 * $urandom_range(0, W - 1);
                2:       a = IB + 4 * $urandom_range(0, W - 1) + $urandom_range(1, 3);
                default: a = $urandom;
            endcase
            instr_address = a; #1;
            checks++;
            if (instr_readdata !== exp_instr(a)) begin
                errors++; $display("FAIL fetch_rand addr %h got %h exp %h", a, instr_readdata, exp_instr(a));
            end
        end
        instr_address = IB;
        cyc();
    endtask

    task automatic test_data_rw();
        int unsigned idx;
        logic [31:0] d;
        logic en, rd;
        // Directed read-during-write at word 4.
        data_address = 32'h10; data_writedata = 32'hF0000000;
        data_write = 1'b1; data_read = 1'b1; clk_enable = 1'b1; #1;
        checks++; if (data_readdata !== ram_m[4]) begin errors++; $display("FAIL rdw_old got %h exp %h", data_readdata, ram_m[4]); end
        cyc();
        ram_m[4] = 32'hF0000000;
        data_write = 1'b0; #1;
        checks++; if (data_readdata !== 32'hF0000000) begin errors++; $display("FAIL rdw_new got %h exp F0000000", data_readdata); end
        data_read = 1'b0; #1;
        checks++; if (data_readdata !== 32'h0) begin errors++; $display("FAIL read_off got %h exp 0", data_readdata); end
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, W - 1);
            d = $urandom; en = ($urandom % 4) != 0; rd = $urandom % 2;
            data_address = idx << 2; data_writedata = d;
            data_write = 1'b1; data_read = rd; clk_enable = en; #1;
            checks++;
            if (data_readdata !== exp_data(data_address, rd)) begin
                errors++; $display("FAIL wr_cycle_read idx %0d got %h exp %h", idx, data_readdata, exp_data(data_address, rd));
            end
            cyc();
            if (en) ram_m[idx] = d;
            data_write = 1'b0; data_read = 1'b1; clk_enable = 1'b1; #1;
            checks++;
            if (data_readdata !== ram_m[idx]) begin
                errors++; $display("FAIL wr_readback idx %0d en %b got %h exp %h", idx, en, data_readdata, ram_m[idx]);
            end
        end
        // Out-of-window and misaligned writes must not land anywhere.
        data_read = 1'b0; data_write = 1'b1; data_writedata = 32'h5A5A5A5A;
        data_address = 4 * W; cyc();
        data_address = 32'h11; cyc();
        data_write = 1'b0; data_read = 1'b1; data_address = 32'h0; #1;
        checks++; if (data_readdata !== ram_m[0]) begin errors++; $display("FAIL oow_write word0 got %h exp %h", data_readdata, ram_m[0]); end
        data_address = 32'h10; #1;
        checks++; if (data_readdata !== ram_m[4]) begin errors++; $display("FAIL misaligned_write word4 got %h exp %h", data_readdata, ram_m[4]); end
        // Preload and CPU write to the same word on the same edge.
        data_read = 1'b0; data_write = 1'b1; data_address = 32'h14; data_writedata = 32'hBBBBBBBB;
        load(1'b1, 5, 32'hAAAAAAAA);
        data_write = 1'b0; data_read = 1'b1; #1;
        checks++; if (data_readdata !== 32'hAAAAAAAA) begin errors++; $display("FAIL preload_wins got %h exp AAAAAAAA", data_readdata); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL idle_no_fault got %b exp 0", fault); end
        data_read = 1'b0;
        cyc();
    endtask

    task automatic test_done();
        int n, k, expc;
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 5 : $urandom_range(2, 20);
            reset = 1'b1; active = 1'b0; clk_enable = 1'b1;
            cyc();
            reset = 1'b0;
            k = 0;
            while (k < n) begin
                if ($urandom % 3 == 0) begin
                    clk_enable = 1'b0; active = $urandom % 2;
                end else begin
                    clk_enable = 1'b1; active = 1'b1; k++;
                end
                cyc();
                expc = (k == 0) ? 0 : k - 1;
                checks++;
                if (cycle_count !== expc || done !== 1'b0) begin
                    errors++; $display("FAIL run_progress run %0d count %0d done %b exp count %0d done 0", r, cycle_count, done, expc);
                end
            end
            clk_enable = 1'b1; active = 1'b0;
            cyc();
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done run %0d got %b exp 1", r, done); end
            checks++; if (cycle_count !== n) begin errors++; $display("FAIL run_count run %0d got %0d exp %0d", r, cycle_count, n); end
            active = 1'b1;
            cyc(); cyc();
            checks++;
            if (done !== 1'b1 || timeout !== 1'b0 || cycle_count !== n) begin
                errors++; $display("FAIL done_terminal run %0d done %b timeout %b count %0d exp 1 0 %0d", r, done, timeout, cycle_count, n);
            end
        end
        active = 1'b0;
    endtask

    task automatic test_fault();
        // First fault: misaligned read.
        start_run();
        data_read = 1'b1; data_address = 32'h12; #1;
        checks++; if (data_readdata !== 32'h0) begin errors++; $display("FAIL misaligned_read got %h exp 0", data_readdata); end
        cyc();
        data_read = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_addr !== 32'h12) begin
            errors++; $display("FAIL fault_capture fault %b addr %h exp 1 00000012", fault, fault_addr);
        end
        data_read = 1'b1; data_address = 32'h10; #1;
        checks++; if (data_readdata !== ram_m[4]) begin errors++; $display("FAIL read_after_fault got %h exp %h", data_readdata, ram_m[4]); end
        cyc();
        data_read = 1'b0; data_write = 1'b1; data_address = 32'h33;
        cyc();
        data_write = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_addr !== 32'h12) begin
            errors++; $display("FAIL fault_sticky fault %b addr %h exp 1 00000012", fault, fault_addr);
        end
        // Read and write together: fault and drop the write.
        start_run();
        data_read = 1'b1; data_write = 1'b1; data_address = 32'h20; data_writedata = ~ram_m[8];
        cyc();
        data_write = 1'b0; #1;
        checks++; if (fault_addr !== 32'h20) begin errors++; $display("FAIL rw_fault_addr got %h exp 00000020", fault_addr); end
        checks++; if (data_readdata !== ram_m[8]) begin errors++; $display("FAIL rw_write_dropped got %h exp %h", data_readdata, ram_m[8]); end
        data_read = 1'b0;
        // Gated cycle ignores faults; then data address beats instruction address.
        start_run();
        clk_enable = 1'b0; data_read = 1'b1; data_address = 32'h13; instr_address = IB + 4 * W;
        cyc();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL gated_no_fault got %b exp 0", fault); end
        clk_enable = 1'b1; data_address = 32'h40000000;
        cyc();
        data_read = 1'b0; instr_address = IB;
        checks++; if (fault_addr !== 32'h40000000) begin errors++; $display("FAIL data_priority got %h exp 40000000", fault_addr); end
        // Instruction fetch below the window while active.
        start_run();
        instr_address = IB - 4;
        cyc();
        instr_address = IB;
        checks++;
        if (fault !== 1'b1 || fault_addr !== IB - 4) begin
            errors++; $display("FAIL instr_fault fault %b addr %h exp 1 %h", fault, fault_addr, IB - 4);
        end
        active = 1'b0;
    endtask

    task automatic test_timeout();
        start_run();
        repeat (T - 2) cyc();
        checks++;
        if (timeout !== 1'b0 || cycle_count !== T - 2) begin
            errors++; $display("FAIL pre_timeout timeout %b count %0d exp 0 %0d", timeout, cycle_count, T - 2);
        end
        cyc();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", timeout); end
        checks++; if (cycle_count !== T - 1) begin errors++; $display("FAIL timeout_count got %0d exp %0d", cycle_count, T - 1); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL timeout_done got %b exp 0", done); end
        active = 1'b0;
        data_write = 1'b1; data_address = 32'h40; data_writedata = 32'h600DF00D;
        cyc();
        ram_m[16] = 32'h600DF00D;
        data_write = 1'b0; data_read = 1'b1; #1;
        checks++;
        if (done !== 1'b0 || timeout !== 1'b1 || cycle_count !== T - 1) begin
            errors++; $display("FAIL timeout_terminal done %b timeout %b count %0d exp 0 1 %0d", done, timeout, cycle_count, T - 1);
        end
        checks++; if (data_readdata !== 32'h600DF00D) begin errors++; $display("FAIL write_in_timeout got %h exp 600DF00D", data_readdata); end
        data_read = 1'b0;
    endtask

    task automatic test_reset_midrun();
        start_run();
        cyc(); cyc();
        data_write = 1'b1; data_address = 32'hC; data_writedata = 32'h13579BDF;
        cyc();
        ram_m[3] = 32'h13579BDF;
        data_write = 1'b0; data_read = 1'b1; data_address = 32'h2;
        cyc();
        data_read = 1'b0;
        reset = 1'b1;
        cyc();
        checks++;
        if (fault !== 1'b0 || fault_addr !== 32'h0 || cycle_count !== 32'h0 || done !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL midrun_reset fault %b addr %h count %0d done %b timeout %b exp all 0", fault, fault_addr, cycle_count, done, timeout);
        end
        reset = 1'b0; active = 1'b0;
        repeat (3) cyc();
        checks++;
        if (done !== 1'b0 || cycle_count !== 32'h0) begin
            errors++; $display("FAIL idle_after_reset done %b count %0d exp 0 0", done, cycle_count);
        end
        data_read = 1'b1; data_address = 32'hC; #1;
        checks++; if (data_readdata !== 32'h13579BDF) begin errors++; $display("FAIL ram_kept got %h exp 13579BDF", data_readdata); end
        data_read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b0; active = 1'b0;
        instr_address = IB; data_address = '0; data_writedata = '0;
        data_write = 1'b0; data_read = 1'b0;
        load_en = 1'b0; load_sel = 1'b0; load_word = '0; load_data = '0;
        test_reset();
        test_instr_read();
        test_data_rw();
        test_done();
        test_fault();
        test_timeout();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_harvard_mem.md
# mips_harvard_mem

Memory responder for the Harvard MIPS CPU. It serves the CPU's instruction and data ports and records run status for the testbenches:
- word-wide instruction ROM window at the reset vector, with combinational read;
- word-wide data RAM window, with combinational read and single-cycle write;
- a run monitor that detects program completion (falling `active`), timeout and bus faults.

It sits between each instruction testbench and `mips_cpu_harvard`, replacing hand-driven `instr_readdata`/`data_readdata`.

## Interface
Parameters:
- `INSTR_BASE`, 32'hBFC00000, byte address of instruction word 0
- `INSTR_WORDS`, 1024, instruction ROM depth (power of two)
- `DATA_BASE`, 32'h00000000, byte address of data word 0
- `DATA_WORDS`, 1024, data RAM depth (power of two)
- `TIMEOUT_CYCLES`, 10000, enabled run cycles before timeout

Ports:
- `clk` in 1: single clock, all state on posedge
- `reset` in 1: synchronous, active-high
- `clk_enable` in 1: same enable fed to the CPU; gates RAM writes and run counters
- `active` in 1: CPU active flag
- `instr_address` in 32: CPU fetch byte address
- `instr_readdata` out 32: fetched word (combinational)
- `data_address` in 32: CPU data byte address
- `data_write` in 1: write strobe
- `data_read` in 1: read strobe
- `data_writedata` in 32: write word
- `data_readdata` out 32: read word (combinational)
- `load_en` in 1: preload write, accepted even while in reset
- `load_sel` in 1: preload target, 0 = instruction ROM, 1 = data RAM
- `load_word` in 32: word index for preload
- `load_data` in 32: preload data
- `done` out 1: program finished
- `timeout` out 1: cycle budget exhausted
- `fault` out 1: bus error latched
- `fault_addr` out 32: address of the first fault
- `cycle_count` out 32: enabled cycles spent in RUN

## Operation
- **Instruction read:**
  - in window (`INSTR_BASE` to `INSTR_BASE+4*INSTR_WORDS-1`) and aligned: `instr_readdata` = rom[(addr-INSTR_BASE)>>2];
  - otherwise it reads 32'h00000000 (NOP).
- **Data read:**
  - `data_readdata` = ram[(addr-DATA_BASE)>>2] when `data_read` is high, the address is in window and aligned;
  - otherwise it is 0.
- **Data write:** on posedge when `data_write && clk_enable` and the address is in window and aligned, ram[idx] <= `data_writedata`.
- **Read-during-write, same address:** `data_readdata` shows the old word. The new word is visible the cycle after the edge.
- **Fault:** raised on the first enabled RUN cycle with any of:
  - `data_read && data_write` both high;
  - a data strobe with a misaligned or out-of-window address;
  - an instruction fetch outside the window while `active`.
- **On fault:**
  - `fault` is set and sticky until reset;
  - `fault_addr` captures the offending address, data address taking priority over instruction address;
  - the faulting write is dropped.
- **Run-monitor FSM states:** IDLE, RUN, DONE, TIMEOUT.
  - IDLE -> RUN: on the first enabled cycle after reset with `active`=1.
  - RUN -> DONE: when `active`=0 on an enabled cycle; `done` is set.
  - RUN -> TIMEOUT: when `cycle_count` reaches `TIMEOUT_CYCLES-1` while still active; `timeout` is set.
  - If both conditions hold in the same cycle, DONE wins.
  - DONE and TIMEOUT are terminal until reset. RAM writes remain functional in them.
- **Arithmetic:** address offsets are 32-bit unsigned subtraction. Window check is offset < 4*WORDS, so addresses below the base wrap to large values and fail. `cycle_count` saturates at 32'hFFFFFFFF.

## Timing
- Reads have zero latency (combinational). Writes and preloads commit at the posedge and are visible in the next cycle.
- Reset values: state IDLE, `done`=0, `timeout`=0, `fault`=0, `fault_addr`=0, `cycle_count`=0.
- Memory contents are not cleared by reset. The bench preloads during or after reset.
- Reset mid-run returns to IDLE next cycle with all status cleared. RAM and ROM contents are kept.
- `clk_enable`=0: no write, no count, no state transition, no fault capture. Reads still respond.
- `load_en` with an out-of-range `load_word` is ignored and does not raise a fault.
- Preload and a CPU write to the same RAM word in the same cycle: the preload wins.

## Structure
- The shared package `mips_mem_pkg` holds:
  - the run-state enum;
  - `INSTR_BASE`/`DATA_BASE` defaults;
  - the NOP constant;
  - a `word_index` function for offset/alignment/window decoding.
- One natural sub-module: `mips_mem_window`, a parameterised word array with combinational read port, write port and in-window decode, instantiated once for ROM and once for RAM.
- The run-monitor FSM and fault latch live in the top module.

## Test plan
- Preload rom[0]=32'h24010014, fetch `instr_address`=32'hBFC00000 -> `instr_readdata`=32'h24010014; fetch 32'hBFC00000-4 -> 0.
- Write 32'hF0000000 to 32'h00000010, read the same address in the next cycle -> 32'hF0000000. In the write cycle itself the old value reads back.
- `data_read` at 32'h00000012 -> `data_readdata`=0, `fault`=1, `fault_addr`=32'h00000012; a later valid access leaves these unchanged.
- Hold `active`=1 for 10000 enabled cycles -> `timeout`=1, `cycle_count`=9999, `done`=0.
- `active` 1 for 5 cycles then 0 -> `done`=1 one cycle later, `cycle_count`=5. With `clk_enable`=0 inserted mid-run, the count excludes the gated cycles.
- Assert `reset` in RUN after a RAM write -> status cleared, state IDLE, RAM word still reads back.
